oiface_mmio: RTL and testbench

Parametrised memory-mapped I/O port between the CPU data bus and the board LEDs and switches. It replaces direct combinational switch/LED wiring with:
- a synchronised, debounced switch path
- a switch rising-edge capture register
- a one-cycle request/acknowledge bus handshake
- a registered, mode-driven LED display mux (halt, upload-status and debug views).

It sits between the CPU memory stage (MMIO decode) and the board pins.

---
 rtl/oiface_pkg.sv | 30 +++
 rtl/oiface_mmio_switch_debouncer.sv | 68 ++++++
 rtl/oiface_mmio.sv | 130 +++++++++++++
 tb/tb_oiface_mmio.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/oiface_pkg.sv
// oiface_pkg: shared constants for the MMIO I/O port.
//   - Register map: LED, switch level, switch edges, status.
//   - CPU mode codes that drive the LED display mux.
//   - Small helpers used by the top level and by the debouncer.
package oiface_pkg;

    // Register select values carried on io_addr_i.
    localparam logic [1:0] ADDR_LED  = 2'd0;
    localparam logic [1:0] ADDR_SW   = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    // CPU mode codes with a dedicated LED view.
    localparam int MODE_HALT = 2;
    localparam int MODE_UPG  = 6;

    // Natural width of the debug LED view before it is fitted to LED_W.
    localparam int DBG_VIEW_W = 24;

    // Counter width able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Low byte of PC+4, minus one. Wraps modulo 256 (0x00 -> 0xFF).
    function automatic logic [7:0] pc_minus_one(input logic [7:0] pc);
        return pc - 8'd1;
    endfunction

endpackage

// File: rtl/oiface_mmio_switch_debouncer.sv
// switch_debouncer: 2-flop synchroniser followed by a shared debounce counter.
// Ports:
//   clk_i      system clock
//   reset_n_i  synchronous active-low reset
//   raw_sw     asynchronous board switches
//   db_sw      debounced switch vector
//   rise       one-cycle pulse per bit, high on the cycle db_sw goes 0->1
module switch_debouncer
    import oiface_pkg::*;
#(
    parameter int SW_W     = 24,
    parameter int DBNC_CYC = 16
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [SW_W-1:0] raw_sw,
    output logic [SW_W-1:0] db_sw,
    output logic [SW_W-1:0] rise
);

    localparam int            CW      = cnt_width(DBNC_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DBNC_CYC);

    logic [SW_W-1:0] sync1_reg;
    logic [SW_W-1:0] sync2_reg;
    logic [SW_W-1:0] prev_reg;
    logic [SW_W-1:0] db_reg;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic            stable;
    logic            load;

    // A single counter serves all bits: any bit moving restarts the wait,
    // so the whole vector is accepted only once every bit has settled.
    always_comb begin
        stable   = (sync2_reg == prev_reg);
        cnt_next = cnt_reg;
        if (!stable) begin
            cnt_next = '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + 1'b1;
        end
        // Load exactly on the cycle the counter reaches its terminal value.
        load = stable && (cnt_reg == CNT_MAX - 1'b1);
        rise = load ? (sync2_reg & ~db_reg) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
            db_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw_sw;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            cnt_reg   <= cnt_next;
            if (load) begin
                db_reg <= sync2_reg;
            end
        end
    end

    assign db_sw = db_reg;

endmodule

// File: rtl/oiface_mmio.sv
// oiface_mmio: memory-mapped port between the CPU data bus and board LEDs/switches.
// Ports:
//   clk_i, reset_n_i          clock, synchronous active-low reset
//   switch_i / led_o          raw board switches / registered LED drive
//   mode_i, exc_code_i        CPU mode and exception code (status + LED mux)
//   upg_status_i              UART upload status nibble
//   dbg_pc_i, dbg_instr_i     debug view sources
//   io_req_i..io_wdata_i      bus request (one-cycle qualified)
//   io_rdata_o, io_ack_o      response, ack one cycle after the request
module oiface_mmio
    import oiface_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int LED_W    = 24,
    parameter int SW_W     = 24,
    parameter int MODE_W   = 4,
    parameter int DBNC_CYC = 16
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [SW_W-1:0]   switch_i,
    output logic [LED_W-1:0]  led_o,
    input  logic [MODE_W-1:0] mode_i,
    input  logic [3:0]        exc_code_i,
    input  logic [3:0]        upg_status_i,
    input  logic [31:0]       dbg_pc_i,
    input  logic [31:0]       dbg_instr_i,
    input  logic              io_req_i,
    input  logic              io_we_i,
    input  logic [1:0]        io_addr_i,
    input  logic [DATA_W-1:0] io_wdata_i,
    output logic [DATA_W-1:0] io_rdata_o,
    output logic              io_ack_o
);

    logic [SW_W-1:0]       sw_db;
    logic [SW_W-1:0]       sw_rise;
    logic [DATA_W-1:0]     led_reg;
    logic [SW_W-1:0]       edge_reg;
    logic [SW_W-1:0]       edge_next;
    logic                  ovf_reg;
    logic                  ovf_next;
    logic                  ack_reg;
    logic [DATA_W-1:0]     rdata_reg;
    logic [DATA_W-1:0]     rdata_next;
    logic                  tog_reg;
    logic [LED_W-1:0]      led_out_reg;
    logic [LED_W-1:0]      led_next;
    logic [DBG_VIEW_W-1:0] dbg_view;
    logic                  rd_en;
    logic                  wr_led;
    logic                  edge_clr;
    logic                  stat_clr;
    logic                  unused_bits;

    switch_debouncer #(
        .SW_W     (SW_W),
        .DBNC_CYC (DBNC_CYC)
    ) u_debouncer (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .raw_sw    (switch_i),
        .db_sw     (sw_db),
        .rise      (sw_rise)
    );

    always_comb begin
        rd_en    = io_req_i && !io_we_i;
        wr_led   = io_req_i && io_we_i && (io_addr_i == ADDR_LED);
        edge_clr = rd_en && (io_addr_i == ADDR_EDGE);
        stat_clr = rd_en && (io_addr_i == ADDR_STAT);

        // A fresh edge survives a coincident clear (set wins).
        edge_next = edge_clr ? sw_rise : (edge_reg | sw_rise);
        ovf_next  = (|(sw_rise & edge_reg)) || (ovf_reg && !stat_clr);

        rdata_next = '0;
        if (rd_en) begin
            case (io_addr_i)
                ADDR_LED:  rdata_next = led_reg;
                ADDR_SW:   rdata_next = DATA_W'(sw_db);
                ADDR_EDGE: rdata_next = DATA_W'(edge_reg);
                default:   rdata_next = DATA_W'({ovf_reg, exc_code_i, mode_i});
            endcase
        end

        dbg_view = {tog_reg, mode_i[2:0], pc_minus_one(dbg_pc_i[7:0]),
                    dbg_instr_i[31:26], dbg_instr_i[5:0]};

        if (mode_i == MODE_W'(MODE_HALT)) begin
            led_next = '1;
        end else if (sw_db[SW_W-1]) begin
            led_next = LED_W'(dbg_view);
        end else if (mode_i == MODE_W'(MODE_UPG)) begin
            led_next = LED_W'(upg_status_i);
        end else begin
            led_next = {mode_i, led_reg[LED_W-MODE_W-1:0]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            led_reg     <= '0;
            edge_reg    <= '0;
            ovf_reg     <= 1'b0;
            ack_reg     <= 1'b0;
            rdata_reg   <= '0;
            tog_reg     <= 1'b0;
            led_out_reg <= '0;
        end else begin
            if (wr_led) begin
                led_reg <= io_wdata_i;
            end
            edge_reg    <= edge_next;
            ovf_reg     <= ovf_next;
            ack_reg     <= io_req_i;
            rdata_reg   <= rdata_next;
            tog_reg     <= !tog_reg;
            led_out_reg <= led_next;
        end
    end

    // Bits of the debug buses that the LED view does not display.
    assign unused_bits = ^{dbg_pc_i[31:8], dbg_instr_i[25:6]};

    assign led_o      = led_out_reg;
    assign io_ack_o   = ack_reg;
    assign io_rdata_o = rdata_reg;

endmodule

// File: tb/tb_oiface_mmio.sv
module tb_oiface_mmio;

    localparam int DATA_W   = 32;
    localparam int LED_W    = 24;
    localparam int SW_W     = 24;
    localparam int MODE_W   = 4;
    localparam int DBNC_CYC = 16;

    logic              clk_i;
    logic              reset_n_i;
    logic [SW_W-1:0]   switch_i;
    logic [LED_W-1:0]  led_o;
    logic [MODE_W-1:0] mode_i;
    logic [3:0]        exc_code_i;
    logic [3:0]        upg_status_i;
    logic [31:0]       dbg_pc_i;
    logic [31:0]       dbg_instr_i;
    logic              io_req_i;
    logic              io_we_i;
    logic [1:0]        io_addr_i;
    logic [DATA_W-1:0] io_wdata_i;
    logic [DATA_W-1:0] io_rdata_o;
    logic              io_ack_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;   // clock edges since reset was released

    oiface_mmio #(
        .DATA_W   (DATA_W),
        .LED_W    (LED_W),
        .SW_W     (SW_W),
        .MODE_W   (MODE_W),
        .DBNC_CYC (DBNC_CYC)
    ) dut (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .switch_i     (switch_i),
        .led_o        (led_o),
        .mode_i       (mode_i),
        .exc_code_i   (exc_code_i),
        .upg_status_i (upg_status_i),
        .dbg_pc_i     (dbg_pc_i),
        .dbg_instr_i  (dbg_instr_i),
        .io_req_i     (io_req_i),
        .io_we_i      (io_we_i),
        .io_addr_i    (io_addr_i),
        .io_wdata_i   (io_wdata_i),
        .io_rdata_o   (io_rdata_o),
        .io_ack_o     (io_ack_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %-14s 0x%08h", tag, obs);
        end else begin
            $display("FAIL %-14s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_i);
        if (!reset_n_i) cyc = 0;
        else            cyc++;
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic do_read(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        io_req_i  = 1'b1;
        io_we_i   = 1'b0;
        io_addr_i = addr;
        tick();
        check_eq({tag, "_ack"}, 32'(io_ack_o), 32'd1);
        check_eq(tag, io_rdata_o, exp);
        io_req_i  = 1'b0;
    endtask

    logic [31:0] exp_v;

    initial begin
        reset_n_i    = 1'b0;
        switch_i     = '0;
        mode_i       = '0;
        exc_code_i   = 4'h0;
        upg_status_i = 4'h0;
        dbg_pc_i     = '0;
        dbg_instr_i  = '0;
        io_req_i     = 1'b1;
        io_we_i      = 1'b1;
        io_addr_i    = 2'd0;
        io_wdata_i   = 32'hFFFF_FFFF;

        // Reset held with a pending write: nothing acked, LEDs dark.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_ack", 32'(io_ack_o), 32'd0);
            check_eq("rst_led", 32'(led_o), 32'd0);
        end
        reset_n_i = 1'b1;
        io_req_i  = 1'b0;
        io_we_i   = 1'b0;
        tick();
        check_eq("post_rst_ack", 32'(io_ack_o), 32'd0);
        wait_cycles(25);

        // LED write: ack next cycle, led_o one cycle after that.
        io_req_i   = 1'b1;
        io_we_i    = 1'b1;
        io_addr_i  = 2'd0;
        io_wdata_i = 32'h000A_BCDE;
        tick();
        check_eq("wr_ack", 32'(io_ack_o), 32'd1);
        check_eq("wr_rdata", io_rdata_o, 32'd0);
        check_eq("led_lat", 32'(led_o), 32'd0);
        io_req_i = 1'b0;
        io_we_i  = 1'b0;
        tick();
        check_eq("wr_ack_drop", 32'(io_ack_o), 32'd0);
        check_eq("led_wr", 32'(led_o), 32'h000A_BCDE);
        mode_i = 4'd4;
        tick();
        check_eq("led_mode4", 32'(led_o), 32'h004A_BCDE);
        mode_i = 4'd0;
        do_read("rd_led", 2'd0, 32'h000A_BCDE);

        // Write to a read-only register is acked but changes nothing.
        io_req_i   = 1'b1;
        io_we_i    = 1'b1;
        io_addr_i  = 2'd1;
        io_wdata_i = 32'hFFFF_FFFF;
        tick();
        check_eq("ro_wr_ack", 32'(io_ack_o), 32'd1);
        io_we_i = 1'b0;
        do_read("rd_led_ro", 2'd0, 32'h000A_BCDE);

        // Bouncy switch: toggles every 5 cycles, then settles high.
        for (int i = 0; i < 8; i++) begin
            switch_i[0] = ~switch_i[0];
            wait_cycles(5);
        end
        switch_i[0] = 1'b1;
        wait_cycles(17);
        io_req_i  = 1'b1;
        io_we_i   = 1'b0;
        io_addr_i = 2'd1;
        tick();
        check_eq("dbnc_e18", io_rdata_o, 32'd0);
        tick();
        check_eq("dbnc_e19", io_rdata_o, 32'd0);
        tick();
        check_eq("dbnc_e20", io_rdata_o, 32'd1);
        io_req_i = 1'b0;
        do_read("edge_b0", 2'd2, 32'h1);

        // Edge clear colliding with a new edge on bit 3.
        switch_i[3] = 1'b1;
        wait_cycles(18);
        do_read("edge_coll", 2'd2, 32'h0);
        do_read("edge_keep", 2'd2, 32'h8);
        do_read("edge_clr", 2'd2, 32'h0);

        // Two rising edges on bit 5 with no intervening read -> overflow.
        exc_code_i  = 4'hC;
        switch_i[5] = 1'b1;
        wait_cycles(22);
        do_read("stat_no_ovf", 2'd3, 32'h0C0);
        switch_i[5] = 1'b0;
        wait_cycles(22);
        switch_i[5] = 1'b1;
        wait_cycles(22);
        do_read("stat_ovf", 2'd3, 32'h1C0);
        do_read("stat_ovf_clr", 2'd3, 32'h0C0);
        do_read("edge_b5", 2'd2, 32'h20);

        // LED mux priority.
        switch_i[23] = 1'b1;
        wait_cycles(22);
        mode_i = 4'd2;
        tick();
        check_eq("led_halt", 32'(led_o), 32'hFF_FFFF);
        mode_i      = 4'd5;
        dbg_pc_i    = 32'h0000_0000;
        dbg_instr_i = 32'h8C00_002A;
        tick();
        exp_v = 32'h5F_F8EA | (32'((cyc - 1) & 1) << 23);
        check_eq("led_dbg_pc0", 32'(led_o), exp_v);
        dbg_pc_i = 32'h0000_0105;
        tick();
        exp_v = 32'h50_48EA | (32'((cyc - 1) & 1) << 23);
        check_eq("led_dbg_pc5", 32'(led_o), exp_v);
        switch_i[23] = 1'b0;
        wait_cycles(22);
        mode_i       = 4'd6;
        upg_status_i = 4'b1010;
        tick();
        check_eq("led_upg", 32'(led_o), 32'h00_000A);
        mode_i = 4'd0;
        tick();
        check_eq("led_norm", 32'(led_o), 32'h0A_BCDE);

        // Four back-to-back reads, one ack per cycle.
        io_req_i = 1'b1;
        io_we_i  = 1'b0;
        for (int a = 0; a < 4; a++) begin
            io_addr_i = 2'(a);
            tick();
            check_eq("b2b_ack", 32'(io_ack_o), 32'd1);
            case (a)
                0:       exp_v = 32'h000A_BCDE;
                1:       exp_v = 32'h0000_0029;
                2:       exp_v = 32'h0080_0000;
                default: exp_v = 32'h0000_00C0;
            endcase
            check_eq("b2b_rdata", io_rdata_o, exp_v);
        end
        io_req_i = 1'b0;
        tick();
        check_eq("b2b_ack_end", 32'(io_ack_o), 32'd0);
        check_eq("b2b_rd_zero", io_rdata_o, 32'd0);

        // Reset mid-transaction cancels the ack and clears the LED register.
        reset_n_i  = 1'b0;
        io_req_i   = 1'b1;
        io_we_i    = 1'b1;
        io_addr_i  = 2'd0;
        io_wdata_i = 32'h0012_3456;
        tick();
        check_eq("rst2_ack", 32'(io_ack_o), 32'd0);
        check_eq("rst2_led", 32'(led_o), 32'd0);
        reset_n_i = 1'b1;
        io_req_i  = 1'b0;
        io_we_i   = 1'b0;
        tick();
        check_eq("rst2_ack_post", 32'(io_ack_o), 32'd0);
        do_read("rst2_rd_led", 2'd0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
